// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 keypad scanner.
// Holds the key codes, the FSM state type and the row/column decoder.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR   = 4'hA;
  localparam logic [3:0] KEY_HASH   = 4'hB;
  localparam logic [3:0] MAX_DIGITS = 4'd10;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Rows 0..2 hold digits 1..9 left to right; row 3 is "*", "0", "#".
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded-key / ID-register outputs.
// The scanner is the master: it drives the columns and all results.
interface keypad_scanner_if;
  logic [3:0]  fila;
  logic [2:0]  columna;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [39:0] registro;
  logic [3:0]  digit_count;
  logic        reg_full;
  logic        enter_pulse;

  modport master (
    input  fila,
    output columna, key_strobe, key_code, registro, digit_count, reg_full, enter_pulse
  );

  modport slave (
    output fila,
    input  columna, key_strobe, key_code, registro, digit_count, reg_full, enter_pulse
  );
endinterface

// File: rtl/scan_tick.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks.
// Runs independently of the scanner state so column dwell is constant.
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, debounce, decode and the
// 40-bit BCD ID register fed one digit at a time.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  logic tick;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t        state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    key_row_q, key_row_d;
  logic [1:0]    key_col_q, key_col_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          key_strobe_q, key_strobe_d;
  logic          enter_pulse_q, enter_pulse_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [39:0]   registro_q, registro_d;
  logic [3:0]    digit_count_q, digit_count_d;
  logic          reg_full_q, reg_full_d;

  // Only exact single-zero patterns match, so row_hit is one-hot or zero.
  logic [3:0] row_hit;
  for (genvar gi = 0; gi < 4; gi++) begin : g_row_hit
    assign row_hit[gi] = (kp.fila == ~(4'b0001 << gi));
  end

  logic       single_row;
  logic [1:0] row_idx;
  logic [1:0] col_idx;

  assign single_row = |row_hit;

  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_hit[i]) row_idx = 2'(i);
    end
  end

  always_comb begin
    case (col_q)
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  logic [DW-1:0] deb_inc;
  logic          deb_done;
  assign deb_inc  = deb_q + DW'(1);
  assign deb_done = (int'(deb_inc) >= DEBOUNCE_CNT);

  logic       accept;
  logic [3:0] new_key;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    pat_d         = pat_q;
    key_row_d     = key_row_q;
    key_col_d     = key_col_q;
    deb_d         = deb_q;
    key_strobe_d  = 1'b0;
    enter_pulse_d = 1'b0;
    key_code_d    = key_code_q;
    registro_d    = registro_q;
    digit_count_d = digit_count_q;
    accept        = 1'b0;
    new_key       = 4'd0;

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (single_row) begin
            pat_d     = kp.fila;
            key_row_d = row_idx;
            key_col_d = col_idx;
            deb_d     = DW'(1);
            if (DEBOUNCE_CNT <= 1) accept = 1'b1;
            else                   state_d = ST_DEBOUNCE;
          end else begin
            col_d = {col_q[1:0], col_q[2]};
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (kp.fila == pat_q) begin
            deb_d = deb_inc;
            if (deb_done) accept = 1'b1;
          end else begin
            deb_d   = '0;
            state_d = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        deb_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Any low row restarts the release count, so a held key never repeats.
        if (tick) begin
          if (kp.fila == 4'b1111) begin
            if (deb_done) begin
              deb_d   = '0;
              state_d = ST_SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase

    if (accept) begin
      new_key      = decode_key(key_row_d, key_col_d);
      state_d      = ST_HELD;
      key_strobe_d = 1'b1;
      key_code_d   = new_key;
      if (new_key == KEY_STAR) begin
        registro_d    = '0;
        digit_count_d = 4'd0;
      end else if (new_key == KEY_HASH) begin
        enter_pulse_d = 1'b1;
      end else if (digit_count_q < MAX_DIGITS) begin
        registro_d    = {registro_q[35:0], new_key};
        digit_count_d = digit_count_q + 4'd1;
      end
    end

    reg_full_d = (digit_count_d == MAX_DIGITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SCAN;
      col_q         <= 3'b110;
      pat_q         <= 4'b1111;
      key_row_q     <= 2'd0;
      key_col_q     <= 2'd0;
      deb_q         <= '0;
      key_strobe_q  <= 1'b0;
      enter_pulse_q <= 1'b0;
      key_code_q    <= 4'd0;
      registro_q    <= '0;
      digit_count_q <= 4'd0;
      reg_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      pat_q         <= pat_d;
      key_row_q     <= key_row_d;
      key_col_q     <= key_col_d;
      deb_q         <= deb_d;
      key_strobe_q  <= key_strobe_d;
      enter_pulse_q <= enter_pulse_d;
      key_code_q    <= key_code_d;
      registro_q    <= registro_d;
      digit_count_q <= digit_count_d;
      reg_full_q    <= reg_full_d;
    end
  end

  assign kp.columna     = col_q;
  assign kp.key_strobe  = key_strobe_q;
  assign kp.enter_pulse = enter_pulse_q;
  assign kp.key_code    = key_code_q;
  assign kp.registro    = registro_q;
  assign kp.digit_count = digit_count_q;
  assign kp.reg_full    = reg_full_q;
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad driver and decoder for the 4x3 ID-number keypad. It drives the column lines one at a time and samples the row lines, debounces each press, and decodes the key. Digits are assembled into the 40-bit BCD ID register (`registro`) consumed by the ID comparator. It is the driving end of the keypad matrix: it owns the column lines that the keypad path otherwise only reads.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per scan tick (column dwell time); legal range ≥ 2.
- `DEBOUNCE_CNT`, 4: consecutive stable scan ticks required to accept a press or a release; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fila`  in  4  keypad rows, active-low, pulled up; 4'b1111 means no key.
- `columna`  out  3  column drive, one-hot active-low.
- `key_strobe`  out  1  one-cycle pulse when a debounced press is accepted.
- `key_code`  out  4  decoded key, valid while `key_strobe` = 1 and held until the next press.
  - Codes 0–9 are digits; 4'hA is `*`; 4'hB is `#`.
- `registro`  out  40  ten BCD digits; the newest digit is in [3:0].
- `digit_count`  out  4  number of digits entered, 0..10.
- `reg_full`  out  1  asserted when `digit_count` = 10.
- `enter_pulse`  out  1  one-cycle pulse on an accepted `#`.

## Operation
Keypad map (row, column, with column 0 = `columna[0]`):
- r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.

State machine `SCAN` → `DEBOUNCE` → `HELD` → `RELEASE` → `SCAN`:
- `SCAN`:
  - On each tick, `columna` rotates 110 → 101 → 011 → 110.
  - Before rotating, `fila` is sampled.
  - If exactly one row bit is low: latch the row and column, freeze `columna`, load the debounce counter with 1, go to `DEBOUNCE`.
  - Zero rows or more than one row low: keep scanning.
- `DEBOUNCE`:
  - On each tick, if `fila` equals the latched pattern, increment the counter. Otherwise return to `SCAN`; rotation resumes from the frozen column.
  - When the counter reaches `DEBOUNCE_CNT`, go to `HELD`.
- `HELD` (one cycle): assert `key_strobe`, update `key_code`, apply the register action, go to `RELEASE`.
- `RELEASE`:
  - Require `DEBOUNCE_CNT` consecutive ticks with `fila` = 4'b1111; any low bit restarts the count.
  - Then go to `SCAN`. A held key never repeats.

Register actions, applied on the `HELD` cycle:
- Digit, `digit_count` < 10: `registro` ← {`registro`[35:0], digit}; `digit_count` increments.
- Digit, `digit_count` = 10: ignored. `key_strobe` still pulses; `registro` is unchanged.
- `*`: `registro` ← 0; `digit_count` ← 0.
- `#`: `enter_pulse` = 1; `registro` and `digit_count` are unchanged.

## Timing
- Reset values:
  - `columna` = 3'b110.
  - `key_strobe`, `enter_pulse`, `key_code`, `registro`, `digit_count`, `reg_full` = 0.
  - State = `SCAN`; tick divider and debounce counter = 0.
- The tick is a one-cycle pulse every `SCAN_DIV` cycles. The divider runs freely in every state.
- Press latency: `key_strobe` asserts one clock after the tick on which the debounce count reaches `DEBOUNCE_CNT`. That is `DEBOUNCE_CNT`−1 ticks after the detecting tick, plus one clock.
- `registro`, `digit_count`, `reg_full` and `key_code` change on the same edge that raises `key_strobe`.
- `enter_pulse` coincides with `key_strobe` for `#`.
- All outputs are registered; there is no combinational path from `fila`.
- `rst` mid-operation: every output and the state returns to its reset value immediately, then resumes `SCAN` on the first clock after deassertion.
- Counter widths: $clog2(`SCAN_DIV`) for the divider; $clog2(`DEBOUNCE_CNT`+1) for the debounce counter.

## Structure
- Package `keypad_pkg` holds:
  - key code constants (`KEY_STAR` = 4'hA, `KEY_HASH` = 4'hB);
  - the state enum;
  - the 4x3 decode function (row index, column index) → key code.
- One sub-module, `scan_tick`: parameterized free-running divider producing the one-cycle tick.
- Everything else (FSM, debounce, register shifting) lives in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CNT`=3.
1. Reset, then idle (`fila` = 1111) for 40 cycles → `columna` cycles 110, 101, 011 with 4 cycles each; no strobe.
2. Hold row 0 low only while `columna` = 101 (key 2) for 5 ticks, then release → exactly one `key_strobe`, `key_code` = 2, `registro` = 40'h2, `digit_count` = 1.
3. Glitch: row 1 low for 1 tick only → no strobe, scanning resumes, `registro` unchanged.
4. Enter 1,2,3,4,5,6,7,8,9,0 then 5 → `registro` = 40'h1234567890, `reg_full` = 1, the 11th digit is ignored, and `key_strobe` still pulses.
5. Press `#` → `enter_pulse` for one cycle with `registro` unchanged. Then press `*` → `registro` = 0, `digit_count` = 0.
6. Assert `rst` during `DEBOUNCE` and again during `RELEASE` → all outputs return to reset values at once; no strobe follows release.
